mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MEM pipeline stage, directly downstream of the execute stage's EX/MEM register. It consumes the EX/MEM outputs and resolves the branch decision (PCSrc) for the fetch stage. It performs the data-memory load/store with a configurable access latency, stalling upstream while busy. It then registers the results into the MEM/WB pipeline register for write-back.

Parameters:
DEPTH, 256, data memory size in 32-bit words (power of 2); word index = alu_result[log2(DEPTH)+1:2]
MEM_LATENCY, 2, extra wait cycles per load/store (0 = single-cycle access)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
wb_ctl  input  2  write-back control from EX/MEM
branch  input  1  branch instruction flag
memread  input  1  load request
memwrite  input  1  store request
zero  input  1  ALU zero flag
ex_mem_npc  input  32  branch target from EX/MEM
alu_result  input  32  ALU result / byte address
rdata2  input  32  store data
dest_reg  input  5  destination register number
pcsrc  output  1  take branch (combinational)
branch_target  output  32  ex_mem_npc passthrough (combinational)
stall  output  1  hold EX/MEM and earlier stages (combinational)
mem_wb_ctl  output  2  registered write-back control
mem_wb_rdata  output  32  registered load data
mem_wb_alu  output  32  registered ALU result
mem_wb_dest  output  5  registered destination register
mem_wb_misaligned  output  1  registered flag: access had alu_result[1:0] != 0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: all mem_wb_* outputs = 0; FSM = IDLE; wait counter = 0. Memory contents are not reset.
- pcsrc = branch & zero, combinational. It is never gated by stall.
- branch_target = ex_mem_npc.
- Access = memread | memwrite.
- Addressing: the word index uses the low address bits only. Higher bits are ignored (addresses wrap modulo DEPTH words). alu_result[1:0] are ignored for addressing.
- Read path: asynchronous array read.
- Write path: the array is written on a clk edge, only on the commit cycle.
- FSM state IDLE:
  - Access with MEM_LATENCY = 0: commit this cycle; stall = 0.
  - Access with MEM_LATENCY > 0: stall = 1; counter <= MEM_LATENCY-1; next state = WAIT.
  - No access: stall = 0.
- FSM state WAIT:
  - counter != 0: stall = 1; counter decrements.
  - counter == 0: commit cycle; stall = 0; next state = IDLE.
- Access timing: each access occupies MEM_LATENCY+1 cycles. stall is high for exactly the first MEM_LATENCY of them.
- Upstream holds all inputs stable while stall = 1. The block samples operands on the commit cycle.
- MEM/WB register load rules (every clk edge):
  - stall = 0: load wb_ctl, array word (pre-write value), alu_result, dest_reg, and misaligned = access & (alu_result[1:0] != 0).
  - stall = 1: load a bubble (mem_wb_ctl = 00, all other mem_wb_* = 0), so write-back never sees a partial access.
- memread & memwrite together: the store commits. mem_wb_rdata returns the pre-write word (read-before-write).
- Non-access instructions: pass through with one-cycle latency; mem_wb_rdata = word at the current address (don't-care for write-back).
- Back-to-back accesses: after a commit the FSM returns to IDLE. A new access presented the next cycle starts a fresh wait sequence; there are no idle gap cycles.
- Reset during WAIT: FSM returns to IDLE, the pending store is dropped (array unchanged), and outputs clear.
- Misaligned access: performed on the aligned word; only the flag is raised. No trap.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all mem_wb_* = 0, stall = 0, FSM IDLE; pcsrc follows branch & zero even during reset.
- Store then load, MEM_LATENCY = 2:
  - store alu_result = 0x10, rdata2 = 0xDEADBEEF -> stall high 2 cycles, word 4 written on the 3rd edge, MEM/WB = bubble twice then wb_ctl.
  - load 0x10, wb_ctl = 11, dest_reg = 5 -> mem_wb_rdata = 0xDEADBEEF, mem_wb_dest = 5 after the 3rd edge.
- MEM_LATENCY = 0: load/store alternating each cycle -> stall never asserted; a store to 0x20 followed by a load of 0x20 returns the new data one cycle later.
- Branch: branch = 1, zero = 1, ex_mem_npc = 0x00000040 -> pcsrc = 1, branch_target = 0x40 same cycle; with zero = 0 -> pcsrc = 0.
- Wrap and misaligned, DEPTH = 256:
  - store to 0x400 -> lands in word 0.
  - load of 0x13 -> returns word 4 with mem_wb_misaligned = 1.
- Reset mid-WAIT: store 0x55AA55AA to 0x8, assert rst on the 2nd stall cycle -> word 2 keeps its old value, stall = 0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory access with a fixed wait
// latency that stalls upstream, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] ex_mem_npc,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  dest_reg,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic [1:0]  mem_wb_ctl,
    output logic [31:0] mem_wb_rdata,
    output logic [31:0] mem_wb_alu,
    output logic [4:0]  mem_wb_dest,
    output logic        mem_wb_misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ctl_q, ctl_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   alu_q, alu_d;
    logic [4:0]    dest_q, dest_d;
    logic          mis_q, mis_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          access;
    logic          busy;
    logic          commit;
    logic          unused_hi;

    // Addresses wrap modulo DEPTH words; byte offset only feeds the misaligned flag.
    assign idx       = alu_result[AW+1:2];
    assign unused_hi = &{1'b0, alu_result[31:AW+2]};
    assign access    = memread | memwrite;

    assign pcsrc         = branch & zero;
    assign branch_target = ex_mem_npc;
    assign stall         = busy & ~rst;
    assign commit        = access & ~busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && (MEM_LATENCY > 0)) begin
                    busy    = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    busy  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled cycle pushes a bubble so write-back never sees a partial access.
    always_comb begin
        ctl_d   = 2'b00;
        rdata_d = 32'h0;
        alu_d   = 32'h0;
        dest_d  = 5'h0;
        mis_d   = 1'b0;
        if (!busy) begin
            ctl_d   = wb_ctl;
            rdata_d = mem[idx];
            alu_d   = alu_result;
            dest_d  = dest_reg;
            mis_d   = access & (alu_result[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctl_q   <= 2'b00;
            rdata_q <= 32'h0;
            alu_q   <= 32'h0;
            dest_q  <= 5'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            dest_q  <= dest_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && memwrite) begin
            mem[idx] <= rdata2;
        end
    end

    assign mem_wb_ctl        = ctl_q;
    assign mem_wb_rdata      = rdata_q;
    assign mem_wb_alu        = alu_q;
    assign mem_wb_dest       = dest_q;
    assign mem_wb_misaligned = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a MEM_LATENCY=2 instance and a MEM_LATENCY=0 instance.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // latency-2 instance
  logic [1:0]  wb_ctl;
  logic        branch, memread, memwrite, zero;
  logic [31:0] npc, alu, rdata2;
  logic [4:0]  dest;
  logic        pcsrc, stall, mis;
  logic [31:0] btgt, wb_rdata, wb_alu;
  logic [1:0]  wb_ctl_o;
  logic [4:0]  wb_dest;

  // latency-0 instance
  logic [1:0]  wb_ctl0;
  logic        memread0, memwrite0;
  logic [31:0] alu0, rdata20;
  logic        pcsrc0, stall0, mis0;
  logic [31:0] btgt0, wb_rdata0, wb_alu0;
  logic [1:0]  wb_ctl_o0;
  logic [4:0]  wb_dest0;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DEPTH(256), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .wb_ctl(wb_ctl), .branch(branch), .memread(memread),
    .memwrite(memwrite), .zero(zero), .ex_mem_npc(npc), .alu_result(alu),
    .rdata2(rdata2), .dest_reg(dest), .pcsrc(pcsrc), .branch_target(btgt),
    .stall(stall), .mem_wb_ctl(wb_ctl_o), .mem_wb_rdata(wb_rdata),
    .mem_wb_alu(wb_alu), .mem_wb_dest(wb_dest), .mem_wb_misaligned(mis)
  );

  mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .wb_ctl(wb_ctl0), .branch(1'b0), .memread(memread0),
    .memwrite(memwrite0), .zero(1'b0), .ex_mem_npc(32'h0), .alu_result(alu0),
    .rdata2(rdata20), .dest_reg(5'd9), .pcsrc(pcsrc0), .branch_target(btgt0),
    .stall(stall0), .mem_wb_ctl(wb_ctl_o0), .mem_wb_rdata(wb_rdata0),
    .mem_wb_alu(wb_alu0), .mem_wb_dest(wb_dest0), .mem_wb_misaligned(mis0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_ctl = 2'b00; branch = 1'b0; zero = 1'b0; memread = 1'b0; memwrite = 1'b0;
    npc = 32'h0; alu = 32'h0; rdata2 = 32'h0; dest = 5'h0;
  endtask

  // Present one access on the latency-2 instance, hold it through the stall,
  // and return just after the commit edge with MEM/WB holding the result.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] ctl, input logic [4:0] dst);
    int n;
    memread = rd; memwrite = wr; alu = addr; rdata2 = data; wb_ctl = ctl; dest = dst;
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(posedge clk);
      #2;
      if (stall) check({tag, "_bubble_ctl"}, 32'(wb_ctl_o), 32'h0);
    end
    check({tag, "_stall_cycles"}, n, 2);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    wb_ctl0 = 2'b00; memread0 = 1'b0; memwrite0 = 1'b0; alu0 = 32'h0; rdata20 = 32'h0;

    // Reset with random inputs
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_ctl = 2'($urandom_range(0, 3)); branch = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1)); memread = 1'($urandom_range(0, 1));
      memwrite = 1'($urandom_range(0, 1)); npc = $urandom; alu = $urandom;
      rdata2 = $urandom; dest = 5'($urandom_range(0, 31));
      #1;
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_pcsrc", 32'(pcsrc), 32'(branch & zero));
      tick();
    end
    check("rst_wb_ctl", 32'(wb_ctl_o), 32'h0);
    check("rst_wb_rdata", wb_rdata, 32'h0);
    check("rst_wb_alu", wb_alu, 32'h0);
    check("rst_wb_dest", 32'(wb_dest), 32'h0);
    check("rst_wb_mis", 32'(mis), 32'h0);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("post_rst_stall", 32'(stall), 32'h0);
    tick();

    // Branch resolution
    branch = 1'b1; zero = 1'b1; npc = 32'h0000_0040;
    #1;
    check("br_taken_pcsrc", 32'(pcsrc), 32'h1);
    check("br_target", btgt, 32'h0000_0040);
    zero = 1'b0;
    #1;
    check("br_not_taken_pcsrc", 32'(pcsrc), 32'h0);
    idle_inputs();
    tick();

    // Store then load, latency 2
    do_access("st10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 5'd3);
    check("st10_wb_ctl", 32'(wb_ctl_o), 32'h2);
    check("st10_wb_alu", wb_alu, 32'h10);
    check("st10_wb_dest", 32'(wb_dest), 32'd3);
    do_access("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd5);
    check("ld10_rdata", wb_rdata, 32'hDEAD_BEEF);
    check("ld10_dest", 32'(wb_dest), 32'd5);
    check("ld10_ctl", 32'(wb_ctl_o), 32'h3);
    check("ld10_mis", 32'(mis), 32'h0);

    // Wrap and misaligned
    do_access("st400", 1'b0, 1'b1, 32'h400, 32'hA5A5_0000, 2'b00, 5'd0);
    do_access("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 5'd6);
    check("ld0_wrap_rdata", wb_rdata, 32'hA5A5_0000);
    do_access("ld13", 1'b1, 1'b0, 32'h13, 32'h0, 2'b11, 5'd7);
    check("ld13_rdata", wb_rdata, 32'hDEAD_BEEF);
    check("ld13_mis", 32'(mis), 32'h1);

    // Read and write together: store commits, old word returned
    do_access("rw10", 1'b1, 1'b1, 32'h10, 32'h1234_5678, 2'b11, 5'd8);
    check("rw10_prewrite", wb_rdata, 32'hDEAD_BEEF);
    do_access("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd8);
    check("ld10b_rdata", wb_rdata, 32'h1234_5678);

    // Non-access passthrough with an unaligned address
    alu = 32'h11; wb_ctl = 2'b01; dest = 5'd7;
    #1;
    check("pass_stall", 32'(stall), 32'h0);
    tick();
    check("pass_alu", wb_alu, 32'h11);
    check("pass_ctl", 32'(wb_ctl_o), 32'h1);
    check("pass_rdata", wb_rdata, 32'h1234_5678);
    check("pass_mis", 32'(mis), 32'h0);
    idle_inputs();

    // Reset during WAIT drops the pending store
    do_access("st8", 1'b0, 1'b1, 32'h8, 32'h1111_2222, 2'b00, 5'd0);
    memwrite = 1'b1; alu = 32'h8; rdata2 = 32'h55AA_55AA;
    #1;
    check("rw_stall1", 32'(stall), 32'h1);
    tick();
    #1;
    check("rw_stall2", 32'(stall), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rw_stall_after", 32'(stall), 32'h0);
    check("rw_wb_ctl", 32'(wb_ctl_o), 32'h0);
    check("rw_wb_alu", wb_alu, 32'h0);
    tick();
    do_access("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 2'b11, 5'd2);
    check("ld8_kept", wb_rdata, 32'h1111_2222);

    // Latency 0: alternating store/load, no stall
    memwrite0 = 1'b1; alu0 = 32'h20; rdata20 = 32'hCAFE_F00D; wb_ctl0 = 2'b10;
    #1;
    check("l0_st_stall", 32'(stall0), 32'h0);
    tick();
    check("l0_st_ctl", 32'(wb_ctl_o0), 32'h2);
    memwrite0 = 1'b0; memread0 = 1'b1; wb_ctl0 = 2'b11;
    #1;
    check("l0_ld_stall", 32'(stall0), 32'h0);
    tick();
    check("l0_ld_rdata", wb_rdata0, 32'hCAFE_F00D);
    memread0 = 1'b0; memwrite0 = 1'b1; alu0 = 32'h24; rdata20 = 32'h0BAD_F00D;
    #1;
    check("l0_st2_stall", 32'(stall0), 32'h0);
    tick();
    memwrite0 = 1'b0; memread0 = 1'b1; alu0 = 32'h25;
    #1;
    check("l0_ld2_stall", 32'(stall0), 32'h0);
    tick();
    check("l0_ld2_rdata", wb_rdata0, 32'h0BAD_F00D);
    check("l0_ld2_mis", 32'(mis0), 32'h1);
    memread0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
